decoder_3to8_seq: RTL and testbench

Sequenced 3-to-8 decoder: the receiving end of the priority-encoder path. It accepts 3-bit codes (`Y`, `Valid`) through a ready/valid handshake and buffers them in a small FIFO. Each code is replayed as a one-hot 8-bit word `D` held for a programmable number of cycles, with optional idle gaps between words. It sits downstream of the 8:3 priority encoder and drives one-hot select/strobe lines.

---
 rtl/decoder_3to8_seq_if.sv | 13 +
 rtl/decoder_3to8_seq.sv | 167 ++++++++++++++++
 tb/tb_decoder_3to8_seq.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/decoder_3to8_seq_if.sv
// Code-input handshake for decoder_3to8_seq.
//   Y     : 3-bit code from the upstream priority encoder
//   Valid : Y is presented this cycle
//   Ready : decoder FIFO has room; driven by the decoder from its occupancy only
// master = code sender, slave = decoder.
interface decoder_3to8_seq_if;
    logic [2:0] Y;
    logic       Valid;
    logic       Ready;

    modport master (output Y, output Valid, input  Ready);
    modport slave  (input  Y, input  Valid, output Ready);
endinterface

// File: rtl/decoder_3to8_seq.sv
// Sequenced 3-to-8 decoder. Codes arrive through a ready/valid handshake into
// a DEPTH-entry FIFO; each code is replayed as a one-hot byte on D for HOLD
// cycles followed by GAP idle (D=0) cycles.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   in_if      : slave side of the code handshake (Y, Valid, Ready)
//   D          : one-hot decoded word, 0 when not driving
//   D_valid    : D is nonzero
//   Busy       : sequencer is in DRIVE or GAP
//   Count      : FIFO occupancy
module decoder_3to8_seq #(
    parameter int DEPTH = 4,
    parameter int HOLD  = 2,
    parameter int GAP   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    decoder_3to8_seq_if.slave        in_if,
    output logic [7:0]               D,
    output logic                     D_valid,
    output logic                     Busy,
    output logic [$clog2(DEPTH):0]   Count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CMAX  = (HOLD > GAP) ? HOLD : GAP;
    localparam int CW    = $clog2(CMAX + 1);
    localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'((GAP > 0) ? GAP - 1 : 0);
    localparam bit            HAS_GAP  = (GAP > 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // FIFO storage; contents are never cleared, only the pointers/count
    logic [2:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;

    state_t        state_q,  state_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [7:0]    d_q,      d_d;
    logic          dv_q,     dv_d;
    logic          busy_q,   busy_d;

    logic          ready;
    logic          push;
    logic          pop;
    logic          empty;
    logic [7:0]    head_onehot;

    // Ready looks at occupancy only, so a full FIFO refuses a push even on
    // an edge where a pop frees a slot.
    assign ready       = (count_q < DEPTH_C);
    assign push        = in_if.Valid && ready;
    assign empty       = (count_q == '0);
    assign head_onehot = 8'd1 << mem_q[rd_ptr_q];

    assign in_if.Ready = ready;
    assign D           = d_q;
    assign D_valid     = dv_q;
    assign Busy        = busy_q;
    assign Count       = count_q;

    // Sequencer: next state, counter, output word and pop strobe
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_d     = d_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    d_d     = head_onehot;
                    cnt_d   = HOLD_LD;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (HAS_GAP) begin
                    d_d     = 8'h00;
                    cnt_d   = GAP_LD;
                    state_d = S_GAP;
                end else if (!empty) begin
                    // no gap: next word follows directly, D_valid stays high
                    pop   = 1'b1;
                    d_d   = head_onehot;
                    cnt_d = HOLD_LD;
                end else begin
                    d_d     = 8'h00;
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!empty) begin
                    pop     = 1'b1;
                    d_d     = head_onehot;
                    cnt_d   = HOLD_LD;
                    state_d = S_DRIVE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                d_d     = 8'h00;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        // flags are registered alongside D so all three change together
        dv_d   = (d_d != 8'h00);
        busy_d = (state_d != S_IDLE);
    end

    // FIFO pointer/occupancy update
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            d_q      <= 8'h00;
            dv_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            d_q      <= d_d;
            dv_q     <= dv_d;
            busy_q   <= busy_d;
        end
    end

    // A write during reset lands in storage but the cleared pointers and
    // count make it unreachable, so the push is effectively dropped.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_if.Y;
    end

endmodule

// File: tb/tb_decoder_3to8_seq.sv
// Bench for decoder_3to8_seq: two instances (HOLD=2/GAP=1 and HOLD=1/GAP=0).
// Accepted codes go into a per-instance expected queue; a negedge monitor
// segments D into words by HOLD length and checks them against the queue.
module tb_decoder_3to8_seq;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] d_a, d_b;
    logic       dv_a, dv_b, busy_a, busy_b;
    logic [2:0] cnt_a, cnt_b;

    int checks = 0;
    int errors = 0;
    int exp_q0[$];
    int exp_q1[$];
    bit saw_full = 1'b0;

    decoder_3to8_seq_if ifa();
    decoder_3to8_seq_if ifb();

    decoder_3to8_seq #(.DEPTH(4), .HOLD(2), .GAP(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_if(ifa),
        .D(d_a), .D_valid(dv_a), .Busy(busy_a), .Count(cnt_a)
    );

    decoder_3to8_seq #(.DEPTH(4), .HOLD(1), .GAP(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_if(ifb),
        .D(d_b), .D_valid(dv_b), .Busy(busy_b), .Count(cnt_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic [7:0] prev_d [2] = '{8'h00, 8'h00};
    int         run    [2] = '{0, 0};
    int         zrun   [2] = '{100, 100};
    int         hold_v [2] = '{2, 1};
    int         gap_v  [2] = '{1, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic [7:0] d;
            logic       dv, rdy;
            logic [2:0] cnt;
            bit         bnd;
            int         code;
            d   = (i == 0) ? d_a   : d_b;
            dv  = (i == 0) ? dv_a  : dv_b;
            cnt = (i == 0) ? cnt_a : cnt_b;
            rdy = (i == 0) ? ifa.Ready : ifb.Ready;
            if (!rst_n) begin
                prev_d[i] = 8'h00;
                run[i]    = 0;
                zrun[i]   = 100;
            end else begin
                if (i == 0 && !rdy) saw_full = 1'b1;
                if (d != 8'h00) begin
                    bnd = (prev_d[i] == 8'h00) || (d != prev_d[i]) || (run[i] == hold_v[i]);
                    if (bnd) begin
                        if (prev_d[i] != 8'h00) chk(run[i] == hold_v[i], "hold_len", run[i], hold_v[i]);
                        else                    chk(zrun[i] >= gap_v[i], "gap_len", zrun[i], gap_v[i]);
                        if (((i == 0) ? exp_q0.size() : exp_q1.size()) == 0) begin
                            chk(1'b0 == (d != 8'h00), "unexpected_word", d, 0);
                        end else begin
                            code = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                            chk(d == (8'd1 << code), "word", d, 1 << code);
                        end
                        run[i] = 1;
                    end else begin
                        run[i]++;
                    end
                    zrun[i] = 0;
                end else begin
                    if (prev_d[i] != 8'h00) chk(run[i] == hold_v[i], "hold_len", run[i], hold_v[i]);
                    run[i] = 0;
                    if (zrun[i] < 100) zrun[i]++;
                end
                chk(dv == (d != 8'h00), "d_valid", dv, d != 8'h00);
                chk(cnt <= 3'd4, "count_max", cnt, 4);
                chk(rdy == (cnt < 3'd4), "ready", rdy, cnt < 3'd4);
                prev_d[i] = d;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int i, input int code);
        int  n;
        bit  rdy, acc;
        n   = 0;
        acc = 1'b0;
        if (i == 0) begin ifa.Y = 3'(code); ifa.Valid = 1'b1; end
        else        begin ifb.Y = 3'(code); ifb.Valid = 1'b1; end
        while (!acc && n < 500) begin
            rdy = (i == 0) ? ifa.Ready : ifb.Ready;
            @(posedge clk);
            if (rdy) begin
                acc = 1'b1;
                if (i == 0) exp_q0.push_back(code);
                else        exp_q1.push_back(code);
            end
            #1;
            n++;
        end
        if (!acc) chk(acc, "push_timeout", n, 500);
        if (i == 0) ifa.Valid = 1'b0;
        else        ifb.Valid = 1'b0;
    endtask

    task automatic drain(input int i);
        int n;
        n = 0;
        while (n < 2000 && (((i == 0) ? exp_q0.size() : exp_q1.size()) != 0 ||
                            ((i == 0) ? busy_a : busy_b))) begin
            step(1);
            n++;
        end
        chk(n < 2000, "drain_timeout", n, 2000);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        ifa.Y = 3'd0; ifa.Valid = 1'b0;
        ifb.Y = 3'd0; ifb.Valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // reset state
        chk(d_a == 8'h00, "rst_d", d_a, 0);
        chk(dv_a == 1'b0, "rst_dv", dv_a, 0);
        chk(busy_a == 1'b0, "rst_busy", busy_a, 0);
        chk(cnt_a == 3'd0, "rst_count", cnt_a, 0);
        chk(ifa.Ready == 1'b1, "rst_ready", ifa.Ready, 1);
        chk(d_b == 8'h00 && cnt_b == 3'd0 && !busy_b, "rst_b", d_b, 0);

        // idle with Valid low
        for (int k = 0; k < 10; k++) begin
            step(1);
            chk(d_a == 8'h00 && cnt_a == 3'd0 && !busy_a, "idle", d_a, 0);
        end

        // single code 5: 2 cycles of 8'h20 then one gap cycle
        push(0, 5);
        @(negedge clk);
        chk(d_a == 8'h00, "lat_n0_d", d_a, 0);
        chk(cnt_a == 3'd1, "lat_n0_count", cnt_a, 1);
        @(negedge clk);
        chk(d_a == 8'h20, "lat_n1_d", d_a, 8'h20);
        chk(busy_a == 1'b1, "lat_n1_busy", busy_a, 1);
        chk(cnt_a == 3'd0, "lat_n1_count", cnt_a, 0);
        @(negedge clk);
        chk(d_a == 8'h20, "lat_n2_d", d_a, 8'h20);
        @(negedge clk);
        chk(d_a == 8'h00, "lat_n3_d", d_a, 0);
        @(negedge clk);
        chk(busy_a == 1'b0, "lat_n4_busy", busy_a, 0);
        step(1);
        drain(0);

        // backpressure: 8 codes back to back fills the FIFO
        saw_full = 1'b0;
        for (int k = 7; k >= 0; k--) push(0, k);
        drain(0);
        chk(saw_full, "saw_full", saw_full, 1);

        // wrap-around: 0..7 twice with random gaps
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 8; k++) begin
                push(0, k);
                step($urandom_range(0, 3));
            end
        drain(0);

        // random traffic
        for (int k = 0; k < 40; k++) begin
            push(0, $urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) step($urandom_range(1, 4));
        end
        drain(0);

        // back-to-back HOLD=1 GAP=0: 02,04,08 consecutive
        push(1, 1);
        push(1, 2);
        push(1, 3);
        @(negedge clk);
        chk(d_b == 8'h04 && dv_b, "b2b_d1", d_b, 8'h04);
        @(negedge clk);
        chk(d_b == 8'h08 && dv_b, "b2b_d2", d_b, 8'h08);
        @(negedge clk);
        chk(d_b == 8'h00, "b2b_end_d", d_b, 0);
        chk(busy_b == 1'b0, "b2b_end_busy", busy_b, 0);
        step(1);

        // random on GAP=0 instance, includes repeated codes
        for (int k = 0; k < 40; k++) begin
            push(1, $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) step($urandom_range(1, 3));
        end
        drain(1);

        // reset mid-operation: DRIVE with Count=3
        for (int k = 1; k <= 5; k++) push(0, k);
        chk(cnt_a == 3'd3, "pre_rst_count", cnt_a, 3);
        chk(busy_a && dv_a, "pre_rst_busy", busy_a, 1);
        rst_n     = 1'b0;
        ifa.Y     = 3'd6;
        ifa.Valid = 1'b1;
        step(1);
        chk(d_a == 8'h00, "midrst_d", d_a, 0);
        chk(cnt_a == 3'd0, "midrst_count", cnt_a, 0);
        chk(busy_a == 1'b0, "midrst_busy", busy_a, 0);
        chk(dv_a == 1'b0, "midrst_dv", dv_a, 0);
        step(1);
        ifa.Valid = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            step(1);
            chk(d_a == 8'h00 && cnt_a == 3'd0 && !busy_a, "post_rst_quiet", d_a, 0);
        end

        // after reset the FIFO still works
        push(0, 2);
        drain(0);
        chk(exp_q0.size() == 0, "final_q0", exp_q0.size(), 0);
        chk(exp_q1.size() == 0, "final_q1", exp_q1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
